// File: rtl/seq_booth_mult.sv
// seq_booth_mult: sequential radix-2 Booth multiplier, signed or unsigned operands.
//
// Runs WIDTH+1 add/sub-and-shift steps on operands extended to WIDTH+1 bits,
// so one datapath handles both two's-complement and unsigned inputs.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      request, sampled only in IDLE
//   is_signed  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a          multiplicand (sampled with start)
//   b          multiplier (sampled with start)
//   busy       high while in RUN
//   done       one-cycle pulse when product is updated
//   product    result register, holds until the next completion
//
// state  | meaning
// -------+--------------------------------------------------------
// S_IDLE | waiting for start; done may pulse here after completion
// S_RUN  | one Booth step per cycle, count steps remaining
module seq_booth_mult #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int CW = $clog2(WIDTH + 2);

    logic [0:0]        state;
    logic [WIDTH+1:0]  acc;
    logic [WIDTH+1:0]  mcand;
    logic [WIDTH:0]    q;
    logic              q_1;
    logic [CW-1:0]     count;

    logic [WIDTH:0]    ext_a;
    logic [WIDTH:0]    ext_b;
    logic [WIDTH+1:0]  acc_nxt;
    logic [2*WIDTH+2:0] shifted;

    // Extra top bit lets unsigned operands be treated as non-negative signed values.
    assign ext_a = {is_signed & a[WIDTH-1], a};
    assign ext_b = {is_signed & b[WIDTH-1], b};

    always_comb begin
        acc_nxt = acc;
        unique case ({q[0], q_1})
            2'b01:   acc_nxt = acc + mcand;
            2'b10:   acc_nxt = acc - mcand;
            default: acc_nxt = acc;
        endcase
    end

    // Arithmetic right shift of {acc_nxt, q}; the bit shifted out becomes q_1.
    assign shifted = {acc_nxt[WIDTH+1], acc_nxt, q[WIDTH:1]};

    assign busy = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            mcand   <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= {ext_a[WIDTH], ext_a};
                        acc   <= '0;
                        q     <= ext_b;
                        q_1   <= 1'b0;
                        count <= CW'(WIDTH + 1);
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= shifted[2*WIDTH+2:WIDTH+1];
                    q     <= shifted[WIDTH:0];
                    q_1   <= q[0];
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        product <= shifted[2*WIDTH-1:0];
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_booth_mult.md
# seq_booth_mult

Parametrised sequential multiplier that runs radix-2 Booth recoding over `WIDTH+1` iterations and supports both signed and unsigned operands. It is the multi-cycle successor to the team's fixed 6-bit combinational array multiplier. It trades latency for area and adds a start/busy/done handshake, so it can sit directly behind a datapath or ALU controller.

## Interface
- `WIDTH`, default 6: operand width in bits, legal range 2..32.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `a`  in  WIDTH  multiplicand; sampled with `start`.
- `b`  in  WIDTH  multiplier; sampled with `start`.
- `busy`  out  1  high while an operation is in progress (state RUN).
- `done`  out  1  one-cycle pulse when `product` is updated.
- `product`  out  2*WIDTH  result register; holds its value until the next completion.

## Operation
- States: IDLE, RUN.
- Reset: state IDLE; `busy`=0, `done`=0, `product`=0, internal registers cleared.
- **IDLE, `start`=1:**
  - Extend `a` and `b` to WIDTH+1 bits: sign-extend if `is_signed`, zero-extend otherwise.
  - Load M = ext(a) sign-extended to WIDTH+2 bits; A = 0 (WIDTH+2 bits); Q = ext(b); q_1 = 0; count = WIDTH+1.
  - Go to RUN.
- **IDLE, `start`=0:** hold.
- **RUN, each cycle:**
  - Decode {Q[0], q_1}: 01 gives A = A + M; 10 gives A = A − M; 00 and 11 leave A unchanged.
  - Arithmetic-shift {A, Q, q_1} right by 1, replicating A's MSB.
  - Decrement count.
- **RUN, final step (count==1 before decrement):**
  - `product` <= low 2*WIDTH bits of the post-shift {A, Q}.
  - `done` <= 1; go to IDLE.
- Arithmetic rules:
  - A is WIDTH+2 bits so that A − M never overflows, including when M is the most negative value.
  - The full {A,Q} result is exact. The truncated 2*WIDTH-bit `product` is exact for all signed and all unsigned operand pairs.
- `start` in RUN is ignored and not queued. `a`, `b` and `is_signed` may change freely after the load cycle.
- `done` is a pulse: it is deasserted on the cycle after it is asserted unless that cycle completes another operation, which cannot happen back-to-back.

## Timing
- Load edge = the edge where IDLE samples `start`=1; call it edge k.
- `busy`=1 from after edge k through the cycle before completion; it deasserts at edge k+WIDTH+1.
- `product` and `done` update at edge k+WIDTH+1, so latency is WIDTH+1 cycles (7 for WIDTH=6).
- Throughput: one operation per WIDTH+2 cycles when `start` is held high.
- The cycle with `done`=1 is an IDLE cycle, so `start` sampled there is accepted. The next load edge is k+WIDTH+2.
- `rst`=1 mid-RUN aborts at that edge: state IDLE, `busy`=0, `done`=0, `product`=0, and no `done` pulse for the aborted operation.
- `rst` and `start` high together: `rst` wins and the operation is not loaded.

## Test plan
- WIDTH=6, `is_signed`=0, a=63, b=63 → `done` 7 cycles after load; `product`=3969 (12'hF81); `busy` high exactly 7 cycles.
- WIDTH=6, `is_signed`=1, a=6'b100000 (−32), b=−32 → `product`=1024 (12'h400). Then a=−5, b=7 → `product`=12'hFDD (−35).
- `is_signed`=0 vs 1 with a=6'h3F, b=6'h02 → unsigned 126 (12'h07E); signed −2 (12'hFFE).
- Pulse `start` with new operands during RUN → ignored; the original result completes on schedule and there is only one `done` pulse.
- Assert `rst` on the 3rd RUN cycle → next cycle `busy`=0, `product`=0, no `done` pulse. A new `start` afterwards gives a correct result.
- `start` held high continuously with a changing operand stream, plus WIDTH=8 and WIDTH=16 builds → every result matches a reference model, `done` spacing = WIDTH+2, and a random signed/unsigned sweep passes with 1000+ vectors per width.
